sar_adc_ctrl: RTL

Converter side of the soc/eoc/x[7:0] acquisition handshake. It answers start-of-conversion requests from a sampling consumer. Each request runs an 8-bit successive-approximation conversion, using an external DAC and an external comparator. It then publishes the result on x and signals end-of-conversion. It sits between the analog front end (DAC and comparator) and any consumer that raises soc, waits for eoc=0, drops soc, waits for eoc=1, then reads x.

---
 rtl/sar_adc_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: 8-bit successive-approximation converter controller.
// Answers soc with an eoc/x handshake, driving an external DAC and
// sampling an external comparator one bit at a time, MSB first.
module sar_adc_ctrl #(
  parameter int SETTLE = 2  // cycles from DAC update to comparator sample, 1..15
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       soc,
  output logic       eoc,
  output logic [7:0] x,
  output logic [7:0] dac,
  input  logic       cmp
);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  localparam logic [3:0] SMAX = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] bi, bi_n;
  logic       eoc_n;
  logic [7:0] x_n, dac_n;

  // State and all outputs are registered; the comb block only computes next values.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      cnt   <= '0;
      bi    <= '0;
      eoc   <= 1'b1;
      x     <= '0;
      dac   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bi    <= bi_n;
      eoc   <= eoc_n;
      x     <= x_n;
      dac   <= dac_n;
    end
  end

  // Next-state: handshake in IDLE/FINISH, one bit decision every SETTLE cycles in CONV.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bi_n    = bi;
    eoc_n   = eoc;
    x_n     = x;
    dac_n   = dac;
    case (state)
      IDLE: begin
        if (soc) begin
          eoc_n   = 1'b0;
          dac_n   = 8'h80;
          bi_n    = 3'd7;
          cnt_n   = '0;
          state_n = CONV;
        end
      end
      CONV: begin
        if (cnt == SMAX) begin
          cnt_n = '0;
          // Bit-wise trial update only: no carries, so 00/FF saturate naturally.
          if (!cmp) dac_n[bi] = 1'b0;
          if (bi != 3'd0) begin
            dac_n[bi - 3'd1] = 1'b1;
            bi_n             = bi - 3'd1;
          end else begin
            x_n     = dac_n;
            state_n = FINISH;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      FINISH: begin
        // Hold eoc low until the consumer releases soc.
        if (!soc) begin
          eoc_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
